// File: rtl/rfile_pkg.sv
// Shared types and constants for the register file port controller.
//   XLEN / REG_AW    : data width and register index width
//   state_e          : controller FSM state
//   slot_e           : what the register file port does in a given cycle
//   resolve_operand  : bypass priority for one read operand
package rfile_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [0:0] {ARB, DRAIN} state_e;

  typedef enum logic [1:0] {SLOT_IDLE, SLOT_READ, SLOT_WRITE} slot_e;

  // Priority: x0 / unused, same-cycle writeback, youngest queued entry, register file.
  function automatic logic [XLEN-1:0] resolve_operand(
    input logic              use_op,
    input logic [REG_AW-1:0] addr,
    input logic              wb_push,
    input logic [REG_AW-1:0] wb_rd,
    input logic [XLEN-1:0]   wb_data,
    input logic              q_hit,
    input logic [XLEN-1:0]   q_data,
    input logic [XLEN-1:0]   rf_data
  );
    if (!use_op || (addr == '0)) return '0;
    if (wb_push && (wb_rd == addr)) return wb_data;
    if (q_hit) return q_data;
    return rf_data;
  endfunction

endpackage

// File: rtl/rfile_wbq.sv
// Writeback queue: circular FIFO of (rd, data) with two youngest-match lookup ports.
//   push / push_rd / push_data : enqueue (ignored when full)
//   pop                        : dequeue head (ignored when empty)
//   head_rd / head_data        : oldest entry
//   count                      : occupancy; distinguishes full from empty
//   lk_addr / lk_hit / lk_data : per-port lookup of the youngest entry matching lk_addr
module rfile_wbq
  import rfile_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [REG_AW-1:0]           push_rd,
  input  logic [XLEN-1:0]             push_data,
  input  logic                        pop,
  output logic [REG_AW-1:0]           head_rd,
  output logic [XLEN-1:0]             head_data,
  output logic [CntW-1:0]             count,
  input  logic [1:0][REG_AW-1:0]      lk_addr,
  output logic [1:0]                  lk_hit,
  output logic [1:0][XLEN-1:0]        lk_data
);

  logic [REG_AW-1:0] rd_q   [DEPTH];
  logic [XLEN-1:0]   data_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              push_en, pop_en;

  assign push_en   = push && (count_q != CntW'(DEPTH));
  assign pop_en    = pop && (count_q != '0);
  assign count     = count_q;
  assign head_rd   = rd_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push_en) - CntW'(pop_en);
    end
  end

  // Payload needs no reset: count gates every use of it.
  always_ff @(posedge clk) begin
    if (push_en) begin
      rd_q[wr_ptr_q]   <= push_rd;
      data_q[wr_ptr_q] <= push_data;
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    lk_hit  = '0;
    lk_data = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if ((CntW'(i) < count_q) && (rd_q[PtrW'(rd_ptr_q + PtrW'(i))] == lk_addr[p])) begin
          lk_hit[p]  = 1'b1;
          lk_data[p] = data_q[PtrW'(rd_ptr_q + PtrW'(i))];
        end
      end
    end
  end

endmodule

// File: rtl/rfile_port_ctrl.sv
// Register file port controller: serialises operand reads and queued writebacks onto a
// single-mode register file port (reads or one write per cycle, never both).
//   rd_req_* / rd_rsp_* : operand read request (valid/ready) and 1-cycle registered response
//   wb_*                : writeback request (valid/ready); writes to x0 are dropped
//   rf_*                : register file address, data and mode strobes; rf_rs1/rf_rs2 read data
//   wbq_count           : writeback queue occupancy
module rfile_port_ctrl
  import rfile_pkg::*;
#(
  parameter int unsigned WBQ_DEPTH = 2,
  localparam int unsigned CntW = $clog2(WBQ_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rd_req_valid,
  output logic                   rd_req_ready,
  input  logic [REG_AW-1:0]      rd_req_rs1_addr,
  input  logic [REG_AW-1:0]      rd_req_rs2_addr,
  input  logic                   rd_req_use_rs1,
  input  logic                   rd_req_use_rs2,
  output logic                   rd_rsp_valid,
  output logic signed [XLEN-1:0] rd_rsp_rs1,
  output logic signed [XLEN-1:0] rd_rsp_rs2,
  input  logic                   wb_valid,
  output logic                   wb_ready,
  input  logic [REG_AW-1:0]      wb_rd,
  input  logic signed [XLEN-1:0] wb_data,
  output logic [REG_AW-1:0]      rf_rs1_addr,
  output logic [REG_AW-1:0]      rf_rs2_addr,
  output logic [REG_AW-1:0]      rf_rd,
  output logic signed [XLEN-1:0] rf_rd_data,
  output logic                   rf_rd_write,
  output logic                   rf_read_rs1,
  output logic                   rf_read_rs2,
  input  logic signed [XLEN-1:0] rf_rs1,
  input  logic signed [XLEN-1:0] rf_rs2,
  output logic [CntW-1:0]        wbq_count
);

  state_e                 state_q, state_d;
  slot_e                  slot;
  logic                   full, wb_fire, push, pop, rd_fire;
  logic [CntW-1:0]        count_next;
  logic [REG_AW-1:0]      head_rd;
  logic [XLEN-1:0]        head_data;
  logic [1:0][REG_AW-1:0] lk_addr;
  logic [1:0]             lk_hit;
  logic [1:0][XLEN-1:0]   lk_data;
  logic [XLEN-1:0]        op1, op2;
  logic                   rsp_valid_q;
  logic [XLEN-1:0]        rsp_rs1_q, rsp_rs2_q;

  assign full         = (wbq_count == CntW'(WBQ_DEPTH));
  assign wb_ready     = !full;
  assign wb_fire      = wb_valid && wb_ready;
  assign push         = wb_fire && (wb_rd != '0);
  assign rd_req_ready = (state_q == ARB) && !full;
  assign rd_fire      = rd_req_valid && rd_req_ready;
  assign pop          = (slot == SLOT_WRITE);
  assign count_next   = wbq_count + CntW'(push) - CntW'(pop);

  assign lk_addr[0] = rd_req_rs1_addr;
  assign lk_addr[1] = rd_req_rs2_addr;

  rfile_wbq #(
    .DEPTH (WBQ_DEPTH)
  ) u_wbq (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_rd   (wb_rd),
    .push_data (wb_data),
    .pop       (pop),
    .head_rd   (head_rd),
    .head_data (head_data),
    .count     (wbq_count),
    .lk_addr   (lk_addr),
    .lk_hit    (lk_hit),
    .lk_data   (lk_data)
  );

  always_comb begin
    state_d = state_q;
    slot    = SLOT_IDLE;
    case (state_q)
      ARB: begin
        if (full) begin
          state_d = DRAIN;
          slot    = SLOT_WRITE;
        end else if (rd_req_valid) begin
          slot = SLOT_READ;
        end else if (wbq_count != '0) begin
          slot = SLOT_WRITE;
        end
      end
      DRAIN: begin
        if (wbq_count != '0) slot = SLOT_WRITE;
        if (count_next == '0) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
    // Keep the port quiet while reset is held, independent of request inputs.
    if (!rst_n) slot = SLOT_IDLE;
  end

  always_comb begin
    rf_rs1_addr = '0;
    rf_rs2_addr = '0;
    rf_read_rs1 = 1'b0;
    rf_read_rs2 = 1'b0;
    rf_rd       = '0;
    rf_rd_data  = '0;
    rf_rd_write = 1'b0;
    unique case (slot)
      SLOT_READ: begin
        rf_rs1_addr = rd_req_rs1_addr;
        rf_rs2_addr = rd_req_rs2_addr;
        rf_read_rs1 = rd_req_use_rs1;
        rf_read_rs2 = rd_req_use_rs2;
      end
      SLOT_WRITE: begin
        rf_rd       = head_rd;
        rf_rd_data  = head_data;
        rf_rd_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign op1 = resolve_operand(rd_req_use_rs1, rd_req_rs1_addr, push, wb_rd, wb_data,
                               lk_hit[0], lk_data[0], rf_rs1);
  assign op2 = resolve_operand(rd_req_use_rs2, rd_req_rs2_addr, push, wb_rd, wb_data,
                               lk_hit[1], lk_data[1], rf_rs2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      rsp_valid_q <= 1'b0;
      rsp_rs1_q   <= '0;
      rsp_rs2_q   <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rd_fire;
      if (rd_fire) begin
        rsp_rs1_q <= op1;
        rsp_rs2_q <= op2;
      end
    end
  end

  assign rd_rsp_valid = rsp_valid_q;
  assign rd_rsp_rs1   = rsp_rs1_q;
  assign rd_rsp_rs2   = rsp_rs2_q;

endmodule

// File: tb/tb_rfile_port_ctrl.sv
module tb_rfile_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req_valid, rd_req_ready, rd_req_use_rs1, rd_req_use_rs2;
  logic [4:0]  rd_req_rs1_addr, rd_req_rs2_addr;
  logic        rd_rsp_valid;
  logic [31:0] rd_rsp_rs1, rd_rsp_rs2;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr, rf_rd;
  logic [31:0] rf_rd_data, rf_rs1, rf_rs2;
  logic        rf_rd_write, rf_read_rs1, rf_read_rs2;
  logic [1:0]  wbq_count;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  rfile_port_ctrl #(
    .WBQ_DEPTH (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rd_req_valid    (rd_req_valid),
    .rd_req_ready    (rd_req_ready),
    .rd_req_rs1_addr (rd_req_rs1_addr),
    .rd_req_rs2_addr (rd_req_rs2_addr),
    .rd_req_use_rs1  (rd_req_use_rs1),
    .rd_req_use_rs2  (rd_req_use_rs2),
    .rd_rsp_valid    (rd_rsp_valid),
    .rd_rsp_rs1      (rd_rsp_rs1),
    .rd_rsp_rs2      (rd_rsp_rs2),
    .wb_valid        (wb_valid),
    .wb_ready        (wb_ready),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .rf_rs1_addr     (rf_rs1_addr),
    .rf_rs2_addr     (rf_rs2_addr),
    .rf_rd           (rf_rd),
    .rf_rd_data      (rf_rd_data),
    .rf_rd_write     (rf_rd_write),
    .rf_read_rs1     (rf_read_rs1),
    .rf_read_rs2     (rf_read_rs2),
    .rf_rs1          (rf_rs1),
    .rf_rs2          (rf_rs2),
    .wbq_count       (wbq_count)
  );

  // Register file environment: combinational read, write on the clock edge.
  logic [31:0] rf_mem [32];
  logic        mem_init = 1'b0;
  int unsigned rf_wr_cnt;

  assign rf_rs1 = rf_mem[rf_rs1_addr];
  assign rf_rs2 = rf_mem[rf_rs2_addr];

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= (i == 0) ? 32'h0 : 32'h1000 + i;
      rf_mem[5] <= 32'h11;
      rf_mem[6] <= 32'h22;
      rf_wr_cnt <= 0;
      mem_init  <= 1'b1;
    end else if (rf_rd_write) begin
      rf_mem[rf_rd] <= rf_rd_data;
      rf_wr_cnt     <= rf_wr_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  // Scoreboard: architectural state updated in acceptance order; expected responses queued.
  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    int unsigned due;
  } exp_t;

  logic [31:0] arch [32];
  exp_t        sbq [$];
  exp_t        e;
  int unsigned cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      sbq.delete();
      arch = rf_mem;
    end else begin
      if (rd_rsp_valid) begin
        if (sbq.size() == 0) begin
          check_eq("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check_eq("rsp_rs1", rd_rsp_rs1, e.rs1);
          check_eq("rsp_rs2", rd_rsp_rs2, e.rs2);
          check_eq("rsp_latency", cyc, e.due);
        end
      end
      check_eq("strobe_mix", {31'd0, rf_rd_write && (rf_read_rs1 || rf_read_rs2)}, 32'd0);
      if (wb_valid && wb_ready && (wb_rd != 5'd0)) arch[wb_rd] = wb_data;
      if (rd_req_valid && rd_req_ready) begin
        e.rs1 = (rd_req_use_rs1 && rd_req_rs1_addr != 0) ? arch[rd_req_rs1_addr] : 32'h0;
        e.rs2 = (rd_req_use_rs2 && rd_req_rs2_addr != 0) ? arch[rd_req_rs2_addr] : 32'h0;
        e.due = cyc + 1;
        sbq.push_back(e);
      end
    end
  end

  task automatic set_rd(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                        input logic u1, input logic u2);
    rd_req_valid    = v;
    rd_req_rs1_addr = a1;
    rd_req_rs2_addr = a2;
    rd_req_use_rs1  = u1;
    rd_req_use_rs2  = u2;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
    wb_valid = v;
    wb_rd    = rd;
    wb_data  = d;
  endtask

  task automatic go_idle();
    set_rd(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    set_wb(1'b0, 5'd0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_rsp_valid"}, {31'd0, rd_rsp_valid}, 32'd0);
    check_eq({pfx, "_rsp_rs1"}, rd_rsp_rs1, 32'd0);
    check_eq({pfx, "_rsp_rs2"}, rd_rsp_rs2, 32'd0);
    check_eq({pfx, "_count"}, {30'd0, wbq_count}, 32'd0);
    check_eq({pfx, "_rf_strobes"}, {29'd0, rf_rd_write, rf_read_rs1, rf_read_rs2}, 32'd0);
    check_eq({pfx, "_rf_addrs"}, {17'd0, rf_rs1_addr, rf_rs2_addr, rf_rd}, 32'd0);
    check_eq({pfx, "_rf_rd_data"}, rf_rd_data, 32'd0);
    check_eq({pfx, "_readys"}, {30'd0, rd_req_ready, wb_ready}, 32'd3);
  endtask

  int unsigned wr_snap;

  initial begin
    rst_n = 1'b1;
    go_idle();
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Plain read of x5/x6.
    set_rd(1'b1, 5'd5, 5'd6, 1'b1, 1'b1);
    #1;
    check_eq("t1_slot", {29'd0, rf_rd_write, rf_read_rs1, rf_read_rs2}, 32'd3);
    tick();
    go_idle();
    check_eq("t1_valid", {31'd0, rd_rsp_valid}, 32'd1);
    check_eq("t1_rs1", rd_rsp_rs1, 32'h11);
    check_eq("t1_rs2", rd_rsp_rs2, 32'h22);

    // Same-cycle write and read of x3.
    set_wb(1'b1, 5'd3, 32'hDEADBEEF);
    set_rd(1'b1, 5'd3, 5'd0, 1'b1, 1'b0);
    tick();
    go_idle();
    check_eq("t2_rs1", rd_rsp_rs1, 32'hDEADBEEF);
    check_eq("t2_count", {30'd0, wbq_count}, 32'd1);
    check_eq("t2_rf_before", rf_mem[3], 32'h1003);
    tick();
    check_eq("t2_rf_after", rf_mem[3], 32'hDEADBEEF);
    check_eq("t2_count_after", {30'd0, wbq_count}, 32'd0);

    // Two writes to x7, then a read of x7 before drain.
    set_wb(1'b1, 5'd7, 32'h1);
    set_rd(1'b1, 5'd1, 5'd0, 1'b1, 1'b0);
    tick();
    set_wb(1'b1, 5'd7, 32'h2);
    set_rd(1'b1, 5'd7, 5'd0, 1'b1, 1'b0);
    tick();
    go_idle();
    check_eq("t3_rs1", rd_rsp_rs1, 32'h2);
    tick();
    tick();
    check_eq("t3_rf", rf_mem[7], 32'h2);
    check_eq("t3_count", {30'd0, wbq_count}, 32'd0);

    // Read served from the queue.
    set_wb(1'b1, 5'd7, 32'h3);
    set_rd(1'b1, 5'd1, 5'd0, 1'b1, 1'b0);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    set_rd(1'b1, 5'd2, 5'd7, 1'b1, 1'b1);
    tick();
    go_idle();
    check_eq("t3q_rs2", rd_rsp_rs2, 32'h3);
    tick();

    // Fill the queue with reads held valid: drain, then reads resume.
    set_wb(1'b1, 5'd12, 32'hA);
    set_rd(1'b1, 5'd12, 5'd13, 1'b1, 1'b1);
    tick();
    set_wb(1'b1, 5'd13, 32'hB);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    check_eq("t4_full_rdy", {30'd0, rd_req_ready, wb_ready}, 32'd0);
    check_eq("t4_full_slot", {26'd0, rf_rd_write, rf_rd}, {26'd0, 1'b1, 5'd12});
    check_eq("t4_full_count", {30'd0, wbq_count}, 32'd2);
    tick();
    check_eq("t4_drain_rdy", {31'd0, rd_req_ready}, 32'd0);
    check_eq("t4_drain_slot", {26'd0, rf_rd_write, rf_rd}, {26'd0, 1'b1, 5'd13});
    tick();
    check_eq("t4_resume_rdy", {31'd0, rd_req_ready}, 32'd1);
    check_eq("t4_resume_slot", {29'd0, rf_rd_write, rf_read_rs1, rf_read_rs2}, 32'd3);
    check_eq("t4_rf12", rf_mem[12], 32'hA);
    check_eq("t4_rf13", rf_mem[13], 32'hB);
    tick();
    go_idle();
    tick();

    // Write to x0 is accepted and discarded.
    set_wb(1'b1, 5'd0, 32'h55);
    #1 check_eq("t5_wb_ready", {31'd0, wb_ready}, 32'd1);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    check_eq("t5_count", {30'd0, wbq_count}, 32'd0);
    set_rd(1'b1, 5'd0, 5'd0, 1'b1, 1'b1);
    tick();
    go_idle();
    check_eq("t5_rs1", rd_rsp_rs1, 32'h0);
    tick();

    // Reset with a full queue and a response pending.
    set_wb(1'b1, 5'd9, 32'h99);
    set_rd(1'b1, 5'd1, 5'd2, 1'b1, 1'b1);
    tick();
    set_wb(1'b1, 5'd10, 32'hAA);
    set_rd(1'b1, 5'd3, 5'd4, 1'b1, 1'b1);
    tick();
    check_eq("t6_pre_count", {30'd0, wbq_count}, 32'd2);
    check_eq("t6_pre_valid", {31'd0, rd_rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1 check_reset_outputs("t6_reset");
    wr_snap = rf_wr_cnt;
    go_idle();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check_eq("t6_no_write", rf_wr_cnt, wr_snap);
    check_eq("t6_rf9", rf_mem[9], 32'h1009);
    set_rd(1'b1, 5'd9, 5'd10, 1'b1, 1'b1);
    tick();
    go_idle();
    check_eq("t6_rs1", rd_rsp_rs1, 32'h1009);
    check_eq("t6_rs2", rd_rsp_rs2, 32'h100A);

    // Random mix of reads and writebacks over a small register window.
    for (int i = 0; i < 300; i++) begin
      set_rd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      tick();
    end
    go_idle();
    for (int i = 0; i < 10 && wbq_count != 0; i++) tick();
    check_eq("final_drain", {30'd0, wbq_count}, 32'd0);
    tick();
    tick();
    for (int i = 1; i < 32; i++) check_eq($sformatf("final_rf_x%0d", i), rf_mem[i], arch[i]);
    check_eq("final_pending", sbq.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
